// File: rtl/async_fifo_reader_buf.sv
// async_fifo_reader_buf: circular output buffer with occupancy counter and valid/ready pop
module async_fifo_reader_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid = (level != '0);
    assign pop   = valid && ready;
    assign data  = mem[rd_ptr];

    // capture pushed words, advance pointers with explicit wrap, track occupancy
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) rd_ptr <= next_ptr(rd_ptr);
            level <= level + LW'(push) - LW'(pop);
        end
    end
endmodule

// File: rtl/async_fifo_reader.sv
// async_fifo_reader: drains the async FIFO read port into a full-rate valid/ready stream
module async_fifo_reader #(
    parameter int WIDTH     = 8,
    parameter int BUF_DEPTH = 3,
    localparam int LW = $clog2(BUF_DEPTH + 1)
) (
    input  logic             rd_clk,
    input  logic             rd_arstn,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    input  logic             fifo_rd_empty,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [LW-1:0]    buf_level
);
    logic inflight;

    // strobe only while the buffer has room for everything already requested; never looks at m_ready
    assign fifo_rd_en = rd_arstn && !fifo_rd_empty &&
                        (({1'b0, buf_level} + (LW + 1)'(inflight)) < (LW + 1)'(BUF_DEPTH));

    // an accepted strobe means the FIFO presents its word on the next cycle
    always_ff @(posedge rd_clk or negedge rd_arstn) begin
        if (!rd_arstn) inflight <= 1'b0;
        else           inflight <= fifo_rd_en;
    end

    async_fifo_reader_buf #(.WIDTH(WIDTH), .DEPTH(BUF_DEPTH)) u_buf (
        .clk       (rd_clk),
        .arstn     (rd_arstn),
        .push      (inflight),
        .push_data (fifo_rd_data),
        .ready     (m_ready),
        .valid     (m_valid),
        .data      (m_data),
        .level     (buf_level)
    );
endmodule

// File: tb/tb_async_fifo_reader.sv
// tb_async_fifo_reader: randomized bench against a queue-based model of FIFO, in-flight word and buffer
module tb_async_fifo_reader;
    logic       rd_clk = 1'b0;
    logic       rd_arstn = 1'b0;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_rd_empty = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [1:0] buf_level;

    int errors = 0;
    int checks = 0;

    logic [7:0] fq[$];
    logic [7:0] mbuf[$];
    logic       fly = 1'b0;
    logic [7:0] fly_word = 8'h00;
    int cyc, en_cnt, valid_cnt, first_valid, last_valid, max_level, delivered;
    int first_data;

    async_fifo_reader #(.WIDTH(8), .BUF_DEPTH(3)) dut (
        .rd_clk        (rd_clk),
        .rd_arstn      (rd_arstn),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .buf_level     (buf_level)
    );

    always #5 rd_clk = ~rd_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; en_cnt = 0; valid_cnt = 0; first_valid = -1; last_valid = -1;
        max_level = 0; delivered = 0; first_data = -1;
    endtask

    task automatic clear_model();
        mbuf.delete();
        fq.delete();
        fly = 1'b0;
    endtask

    task automatic cycle(input int hide_pct, input int ready_pct);
        logic exp_en, acc, pop;
        @(negedge rd_clk);
        fifo_rd_empty = (fq.size() == 0) || ($urandom_range(99) < hide_pct);
        m_ready = ($urandom_range(99) < ready_pct);
        #1;
        exp_en = rd_arstn && !fifo_rd_empty && (mbuf.size() + int'(fly) < 3);
        check("valid", m_valid, mbuf.size() != 0);
        check("level", buf_level, mbuf.size());
        check("rd_en", fifo_rd_en, exp_en);
        check("lvl_max", buf_level <= 2'd3, 1);
        if (mbuf.size() != 0) check("data", m_data, mbuf[0]);
        if (!rd_arstn) check("rst_data", m_data, 0);
        if (m_valid && m_ready && first_data < 0) first_data = int'(m_data);
        if (exp_en) en_cnt++;
        if (mbuf.size() != 0) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
            last_valid = cyc;
        end
        if (mbuf.size() > max_level) max_level = mbuf.size();
        acc = exp_en;
        pop = (mbuf.size() != 0) && m_ready;
        @(posedge rd_clk);
        #1;
        cyc++;
        if (!rd_arstn) begin
            mbuf.delete();
            fly = 1'b0;
        end else begin
            if (pop) begin
                void'(mbuf.pop_front());
                delivered++;
            end
            if (fly) mbuf.push_back(fly_word);
            fly = acc;
            if (acc) begin
                fly_word = fq.pop_front();
                fifo_rd_data = fly_word;
            end
        end
    endtask

    initial begin
        clear_stats();
        // reset hold with a word waiting in the FIFO
        fq.push_back(8'hA5);
        for (int i = 0; i < 5; i++) cycle(0, 100);
        check("rst_en_cnt", en_cnt, 0);
        clear_model();
        rd_arstn = 1'b1;

        // single word: latency from empty falling to m_valid
        cycle(0, 100);
        cycle(0, 100);
        clear_stats();
        fq.push_back(8'hA5);
        for (int i = 0; i < 6; i++) cycle(0, 100);
        check("single_lat", first_valid, 2);
        check("single_en", en_cnt, 1);
        check("single_data", first_data, 8'hA5);
        check("single_lvl", buf_level, 0);

        // streaming at full rate
        clear_stats();
        for (int i = 0; i < 16; i++) fq.push_back(8'(i));
        for (int i = 0; i < 24; i++) cycle(0, 100);
        check("stream_en", en_cnt, 16);
        check("stream_vcnt", valid_cnt, 16);
        check("stream_span", last_valid - first_valid + 1, 16);
        check("stream_cnt", delivered, 16);

        // back-pressure: stall 8 cycles then drain
        clear_stats();
        for (int i = 0; i < 10; i++) fq.push_back(8'($urandom));
        for (int i = 0; i < 8; i++) cycle(0, 0);
        check("bp_full", buf_level, 3);
        for (int i = 0; i < 16; i++) cycle(0, 100);
        check("bp_max", max_level, 3);
        check("bp_cnt", delivered, 10);

        // random stalls on both sides
        clear_stats();
        for (int i = 0; i < 1000; i++) fq.push_back(8'($urandom));
        for (int g = 0; g < 8000 && delivered < 1000; g++) cycle(30, 60);
        check("rand_cnt", delivered, 1000);

        // mid-stream reset with two buffered words and one in flight
        clear_stats();
        for (int i = 0; i < 5; i++) fq.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 3; i++) cycle(0, 0);
        check("pre_lvl", buf_level, 2);
        check("pre_en", fifo_rd_en, 0);
        #2;
        rd_arstn = 1'b0;
        #1;
        check("arst_valid", m_valid, 0);
        check("arst_data", m_data, 0);
        check("arst_lvl", buf_level, 0);
        check("arst_en", fifo_rd_en, 0);
        clear_model();
        for (int i = 0; i < 2; i++) cycle(0, 100);
        rd_arstn = 1'b1;
        clear_stats();
        fq.push_back(8'h77);
        fq.push_back(8'h78);
        for (int i = 0; i < 8; i++) cycle(0, 100);
        check("post_first", first_data, 8'h77);
        check("post_cnt", delivered, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/async_fifo_reader.md
Name: async_fifo_reader

Overview:
- Read-side drainer for async_fifo; sits entirely in the read clock domain.
- Pulls words from the FIFO read port (rd_en / rd_data / rd_empty) and presents them as a valid/ready stream with full throughput under back-pressure.
- Absorbs the FIFO's one-cycle registered read latency with a small internal buffer, so no combinational path runs from m_ready to fifo_rd_en.

Parameters:
- WIDTH, 8, data word width; must match async_fifo WIDTH.
- BUF_DEPTH, 3, output buffer entries; minimum 3, giving full rate with read latency 1 and no ready-to-rd_en path.

Ports:
- rd_clk  in  1  read-domain clock (same clock as async_fifo rd_clk).
- rd_arstn  in  1  asynchronous active-low reset.
- fifo_rd_en  out  1  read strobe to async_fifo rd_en.
- fifo_rd_data  in  WIDTH  async_fifo rd_data; valid the cycle after an accepted strobe.
- fifo_rd_empty  in  1  async_fifo rd_empty.
- m_valid  out  1  output stream word valid.
- m_ready  in  1  downstream accepts word.
- m_data  out  WIDTH  output stream word.
- buf_level  out  $clog2(BUF_DEPTH+1)  current buffer occupancy.

Behaviour:
- Reset (rd_arstn=0, async assert, sync release):
  - fifo_rd_en=0, m_valid=0, m_data=0, buf_level=0.
  - Read/write pointers=0, inflight=0.
- FIFO read model:
  - An accepted read is fifo_rd_en=1 && fifo_rd_empty=0.
  - fifo_rd_data is sampled exactly 1 cycle later.
  - inflight (1 bit) is set on an accepted read and captures data the following cycle.
- Strobe rule (registered state only):
  - fifo_rd_en = !fifo_rd_empty && (buf_level + inflight) < BUF_DEPTH.
  - fifo_rd_en never depends on m_ready; the buffer therefore never overflows.
- Buffer:
  - Circular buffer of BUF_DEPTH entries.
  - Write pointer advances when inflight=1 (captures fifo_rd_data).
  - Read pointer advances on pop = m_valid && m_ready.
  - Pointers wrap from BUF_DEPTH-1 to 0; a non-power-of-2 depth is handled by explicit compare, not bit truncation.
- Level update:
  - buf_level' = buf_level + inflight - pop.
  - Simultaneous capture and pop leaves the level unchanged.
- Output:
  - m_valid = (buf_level != 0).
  - m_data = buffer entry at the read pointer, driven combinationally from the register array.
  - AXI-stream rule: m_data is stable while m_valid && !m_ready.
- Latency:
  - From an idle, empty buffer, a FIFO word reaches m_valid 2 cycles after fifo_rd_empty falls: strobe cycle, then capture cycle; m_valid rises on the following edge.
- Throughput:
  - 1 word/cycle in steady state with m_ready=1 (level oscillates at 1, inflight=1).
- Boundaries:
  - fifo_rd_empty rising while inflight=1: the in-flight word is still captured; no further strobes.
  - Buffer full (buf_level=BUF_DEPTH): fifo_rd_en=0 until a pop frees a slot. The strobe resumes on the cycle after that pop because the rule uses registered state.
  - m_ready=1 with m_valid=0: no effect.
  - Reset mid-operation: all state clears, including an in-flight word, which is discarded. The FIFO is expected to be reset in the same event.
- Ordering: strict FIFO; no drop, no duplication.

Decomposition:
- No shared package; a single parameter set only.
- Local constant: pointer width = $clog2(BUF_DEPTH).
- One natural sub-module, async_fifo_reader_buf: circular buffer plus level counter, with push/pop/data ports.
- The top level holds only the strobe rule and the inflight flag.

Test Plan:
- Reset hold:
  - Stimulus: rd_arstn=0 for 5 cycles with fifo_rd_empty=0.
  - Required: fifo_rd_en=0, m_valid=0, m_data=0, buf_level=0 throughout.
- Single word:
  - Stimulus: FIFO model holds 0xA5; m_ready=1.
  - Required: fifo_rd_en high 1 cycle; m_valid high with m_data=0xA5 2 cycles after empty fell; buf_level returns to 0.
- Streaming:
  - Stimulus: 16 words 0x00..0x0F; m_ready=1.
  - Required: fifo_rd_en continuous; m_valid continuous for 16 cycles; data in order.
- Back-pressure:
  - Stimulus: 10 words; m_ready=0 for 8 cycles, then 1.
  - Required: buf_level saturates at 3; fifo_rd_en=0 while full; m_data held stable; all 10 words delivered in order with none lost.
- Random stall:
  - Stimulus: 1000 words; random fifo_rd_empty and m_ready.
  - Required: scoreboard match; buf_level ≤ 3 always; no read strobe while buf_level+inflight=3.
- Mid-stream reset:
  - Stimulus: assert rd_arstn=0 with buf_level=2 and inflight=1.
  - Required: outputs clear asynchronously; after release, the next word pushed by the FIFO model appears first.
